// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the RV32I+F datapath: sequences fetch,
// decode and execute, and owns memory, FPU and UART handshakes.
module mc_control_fsm #(
  parameter logic [6:0] IO_IN_OP  = 7'b0001011,
  parameter logic [6:0] IO_OUT_OP = 7'b0101011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        zero,
  input  logic        fpu_valid,
  input  logic        mem_ready,
  input  logic        rx_valid,
  input  logic        tx_ready,
  output logic        pcen,
  output logic        irwrite,
  output logic        regwrite,
  output logic        pcbufwrite,
  output logic        iord,
  output logic        iorf,
  output logic        fregwrite,
  output logic        fpusrca,
  output logic        mode,
  output logic        fpu_go,
  output logic [1:0]  alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [1:0]  fregsrc,
  output logic [2:0]  regsrc,
  output logic [4:0]  alucontrol,
  output logic [3:0]  fpucontrol,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rx_ack,
  output logic        tx_valid,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_FLW   = 7'b0000111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_FSW   = 7'b0100111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FP    = 7'b1010011;

  localparam logic [6:0] F7_FMVXW  = 7'b1110000;
  localparam logic [6:0] F7_FMVWX  = 7'b1111000;
  localparam logic [6:0] F7_FSGNJ  = 7'b0010000;
  localparam logic [6:0] F7_FCMP   = 7'b1010000;
  localparam logic [6:0] F7_FCVTWS = 7'b1100000;
  localparam logic [6:0] F7_FCVTSW = 7'b1101000;

  localparam logic [4:0] ALU_ADD = 5'b00000;

  typedef enum logic [4:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_FPDEC,
    S_FPU_GO,
    S_FPU_WAIT,
    S_FPU_WB,
    S_IN_WAIT,
    S_OUT_WAIT,
    S_ILLEGAL
  } state_t;

  state_t state_q;
  state_t state_d;
  state_t dec_next;
  state_t done_st;
  logic   retire;

  logic [4:0] alu_reg;
  logic [4:0] alu_imm;
  logic [4:0] alu_br;
  logic       is_load;
  logic       is_store;
  logic       fpu_int_wb;

  assign alu_reg  = {1'b0, funct7[5], funct3};
  assign alu_imm  = {1'b0, funct7[5] & (funct3 == 3'b101), funct3};
  assign alu_br   = {2'b10, funct3};
  assign is_load  = (op == OP_LOAD) || (op == OP_FLW);
  assign is_store = (op == OP_STORE) || (op == OP_FSW);
  assign fpu_int_wb = (funct7 == F7_FCMP) || (funct7 == F7_FCVTWS);

  // run is consulted only when an instruction finishes
  assign done_st = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      instret <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire) instret <= instret + 32'd1;
    end
  end

  always_comb begin
    dec_next = S_ILLEGAL;
    unique case (1'b1)
      is_load:            dec_next = S_MEMADR;
      is_store:           dec_next = S_MEMADR;
      op == OP_REG:       dec_next = S_EXEC_R;
      op == OP_IMM:       dec_next = S_EXEC_I;
      op == OP_BR:        dec_next = S_BRANCH;
      op == OP_JAL:       dec_next = S_JAL;
      op == OP_JALR:      dec_next = S_JALR;
      op == OP_LUI:       dec_next = S_LUI;
      op == OP_AUIPC:     dec_next = S_ALUWB;
      op == OP_FP:        dec_next = S_FPDEC;
      op == IO_IN_OP:     dec_next = S_IN_WAIT;
      op == IO_OUT_OP:    dec_next = S_OUT_WAIT;
      default:            dec_next = S_ILLEGAL;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    pcbufwrite = 1'b0;
    iord       = 1'b0;
    iorf       = 1'b0;
    fregwrite  = 1'b0;
    fpusrca    = 1'b0;
    mode       = 1'b0;
    fpu_go     = 1'b0;
    alusrca    = 2'd0;
    alusrcb    = 2'd0;
    pcsrc      = 2'd0;
    fregsrc    = 2'd0;
    regsrc     = 3'd0;
    alucontrol = ALU_ADD;
    fpucontrol = 4'd0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    rx_ack     = 1'b0;
    tx_valid   = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'd1;
        if (mem_ready) begin
          pcen       = 1'b1;
          irwrite    = 1'b1;
          pcbufwrite = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrca = 2'd1;
        alusrcb = 2'd2;
        state_d = dec_next;
      end
      S_MEMADR: begin
        alusrca = 2'd2;
        alusrcb = 2'd2;
        state_d = is_load ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        if (op == OP_LOAD) begin
          regwrite = 1'b1;
          regsrc   = 3'd1;
        end else begin
          fregwrite = 1'b1;
          fregsrc   = 2'd0;
        end
        retire  = 1'b1;
        state_d = done_st;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        iorf    = (op == OP_FSW);
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = done_st;
        end
      end
      S_EXEC_R: begin
        alusrca    = 2'd2;
        alucontrol = alu_reg;
        state_d    = S_ALUWB;
      end
      S_EXEC_I: begin
        alusrca    = 2'd2;
        alusrcb    = 2'd2;
        alucontrol = alu_imm;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = done_st;
      end
      S_BRANCH: begin
        alusrca    = 2'd2;
        alucontrol = alu_br;
        pcen       = zero;
        pcsrc      = 2'd1;
        retire     = 1'b1;
        state_d    = done_st;
      end
      S_JAL: begin
        regwrite = 1'b1;
        regsrc   = 3'd3;
        pcen     = 1'b1;
        pcsrc    = 2'd1;
        retire   = 1'b1;
        state_d  = done_st;
      end
      S_JALR: begin
        alusrca  = 2'd2;
        alusrcb  = 2'd2;
        pcen     = 1'b1;
        pcsrc    = 2'd2;
        regwrite = 1'b1;
        regsrc   = 3'd3;
        retire   = 1'b1;
        state_d  = done_st;
      end
      S_LUI: begin
        regwrite = 1'b1;
        regsrc   = 3'd2;
        retire   = 1'b1;
        state_d  = done_st;
      end
      S_FPDEC: begin
        unique case (1'b1)
          funct7 == F7_FMVXW: begin
            regwrite = 1'b1;
            regsrc   = 3'd5;
            retire   = 1'b1;
            state_d  = done_st;
          end
          funct7 == F7_FMVWX: begin
            fregwrite = 1'b1;
            fregsrc   = 2'd2;
            retire    = 1'b1;
            state_d   = done_st;
          end
          funct7 == F7_FSGNJ: begin
            if (funct3 == 3'b001) begin
              fregwrite = 1'b1;
              fregsrc   = 2'd1;
              retire    = 1'b1;
              state_d   = done_st;
            end else begin
              state_d = S_ILLEGAL;
            end
          end
          default: state_d = S_FPU_GO;
        endcase
      end
      S_FPU_GO: begin
        fpu_go     = 1'b1;
        fpucontrol = funct7[6:3];
        mode       = funct3[0];
        fpusrca    = (funct7 == F7_FCVTSW);
        state_d    = S_FPU_WAIT;
      end
      S_FPU_WAIT: begin
        fpucontrol = funct7[6:3];
        mode       = funct3[0];
        fpusrca    = (funct7 == F7_FCVTSW);
        if (fpu_valid) state_d = S_FPU_WB;
      end
      S_FPU_WB: begin
        fpucontrol = funct7[6:3];
        mode       = funct3[0];
        fpusrca    = (funct7 == F7_FCVTSW);
        if (fpu_int_wb) begin
          regwrite = 1'b1;
          regsrc   = 3'd6;
        end else begin
          fregwrite = 1'b1;
          fregsrc   = 2'd3;
        end
        retire  = 1'b1;
        state_d = done_st;
      end
      S_IN_WAIT: begin
        if (rx_valid) begin
          regwrite = 1'b1;
          regsrc   = 3'd4;
          rx_ack   = 1'b1;
          retire   = 1'b1;
          state_d  = done_st;
        end
      end
      S_OUT_WAIT: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          retire  = 1'b1;
          state_d = done_st;
        end
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: randomized instruction stream,
// expected strobe events and retire counts from an instruction-level model.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst, run, zero;
  logic [6:0]  op, funct7;
  logic [2:0]  funct3;
  logic        fpu_valid, mem_ready, rx_valid, tx_ready;
  logic        pcen, irwrite, regwrite, pcbufwrite, iord, iorf;
  logic        fregwrite, fpusrca, mode, fpu_go;
  logic [1:0]  alusrca, alusrcb, pcsrc, fregsrc;
  logic [2:0]  regsrc;
  logic [4:0]  alucontrol;
  logic [3:0]  fpucontrol;
  logic        mem_req, mem_we, rx_ack, tx_valid, illegal;
  logic [31:0] instret;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .run(run), .op(op), .funct3(funct3),
    .funct7(funct7), .zero(zero), .fpu_valid(fpu_valid),
    .mem_ready(mem_ready), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
    .pcbufwrite(pcbufwrite), .iord(iord), .iorf(iorf),
    .fregwrite(fregwrite), .fpusrca(fpusrca), .mode(mode),
    .fpu_go(fpu_go), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .fregsrc(fregsrc), .regsrc(regsrc),
    .alucontrol(alucontrol), .fpucontrol(fpucontrol),
    .mem_req(mem_req), .mem_we(mem_we), .rx_ack(rx_ack),
    .tx_valid(tx_valid), .illegal(illegal), .instret(instret)
  );

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] FLW   = 7'b0000111;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] FSW   = 7'b0100111;
  localparam logic [6:0] REG   = 7'b0110011;
  localparam logic [6:0] IMM   = 7'b0010011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] FP    = 7'b1010011;
  localparam logic [6:0] IOIN  = 7'b0001011;
  localparam logic [6:0] IOOUT = 7'b0101011;

  logic [34:0] outv;
  assign outv = {pcen, irwrite, regwrite, pcbufwrite, iord, iorf,
                 fregwrite, fpusrca, mode, fpu_go, alusrca, alusrcb,
                 pcsrc, fregsrc, regsrc, alucontrol, fpucontrol,
                 mem_req, mem_we, rx_ack, tx_valid, illegal};

  typedef struct packed {
    logic       pcen;
    logic [1:0] pcsrc;
    logic       irwrite;
    logic       pcbufwrite;
    logic       regwrite;
    logic [2:0] regsrc;
    logic       fregwrite;
    logic [1:0] fregsrc;
    logic       fpu_go;
    logic [3:0] fpucontrol;
    logic       mode;
    logic       fpusrca;
    logic       rx_ack;
    logic       tx_fire;
    logic       mem_fire;
    logic       mem_we;
    logic       iord;
    logic       iorf;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [4:0] alucontrol;
  } ev_t;

  typedef struct { ev_t ev; bit chk_alu; } exp_t;
  typedef struct { int unsigned cnt; int cycles; } ret_t;
  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic z;
  } ins_t;

  exp_t eq[$];
  ret_t rq[$];
  int checks = 0;
  int errors = 0;
  int fetch_cnt = 0;
  int unsigned model_cnt = 0;
  bit fast = 1'b1;
  bit hold_fpu = 1'b0;

  task automatic push_ev(input ev_t e, input bit ca);
    exp_t x;
    x.ev = e;
    x.chk_alu = ca;
    eq.push_back(x);
  endtask

  task automatic push_fetch();
    ev_t e = '0;
    e.mem_fire = 1; e.irwrite = 1; e.pcbufwrite = 1;
    e.pcen = 1; e.alusrcb = 2'd1;
    push_ev(e, 1'b1);
  endtask

  // instruction-level model: what each instruction writes, and its
  // length in cycles when every handshake completes immediately
  task automatic model(input ins_t i, output int cyc);
    ev_t e = '0;
    cyc = 3;
    case (i.op)
      LOAD, FLW: begin
        e.mem_fire = 1; e.iord = 1;
        push_ev(e, 0);
        e = '0;
        if (i.op == LOAD) begin e.regwrite = 1; e.regsrc = 3'd1; end
        else e.fregwrite = 1;
        push_ev(e, 0);
        cyc = 5;
      end
      STORE, FSW: begin
        e.mem_fire = 1; e.mem_we = 1; e.iord = 1;
        e.iorf = (i.op == FSW);
        push_ev(e, 0);
        cyc = 4;
      end
      REG, IMM, AUIPC: begin
        e.regwrite = 1;
        push_ev(e, 0);
        cyc = (i.op == AUIPC) ? 3 : 4;
      end
      BR: begin
        if (i.z) begin
          e.pcen = 1; e.pcsrc = 2'd1; e.alusrca = 2'd2;
          e.alucontrol = {2'b10, i.f3};
          push_ev(e, 1);
        end
      end
      JAL: begin
        e.regwrite = 1; e.regsrc = 3'd3; e.pcen = 1; e.pcsrc = 2'd1;
        push_ev(e, 0);
      end
      JALR: begin
        e.regwrite = 1; e.regsrc = 3'd3; e.pcen = 1; e.pcsrc = 2'd2;
        e.alusrca = 2'd2; e.alusrcb = 2'd2;
        push_ev(e, 1);
      end
      LUI: begin
        e.regwrite = 1; e.regsrc = 3'd2;
        push_ev(e, 0);
      end
      FP: begin
        if (i.f7 == 7'b1110000) begin
          e.regwrite = 1; e.regsrc = 3'd5;
        end else if (i.f7 == 7'b1111000) begin
          e.fregwrite = 1; e.fregsrc = 2'd2;
        end else if (i.f7 == 7'b0010000) begin
          e.fregwrite = 1; e.fregsrc = 2'd1;
        end else begin
          e.fpu_go = 1; e.fpucontrol = i.f7[6:3];
          e.mode = i.f3[0]; e.fpusrca = (i.f7 == 7'b1101000);
          push_ev(e, 0);
          e = '0;
          if (i.f7 == 7'b1010000 || i.f7 == 7'b1100000) begin
            e.regwrite = 1; e.regsrc = 3'd6;
          end else begin
            e.fregwrite = 1; e.fregsrc = 2'd3;
          end
          cyc = 6;
        end
        push_ev(e, 0);
      end
      IOIN: begin
        e.regwrite = 1; e.regsrc = 3'd4; e.rx_ack = 1;
        push_ev(e, 0);
      end
      IOOUT: begin
        e.tx_fire = 1;
        push_ev(e, 0);
      end
      default: cyc = 3;
    endcase
  endtask

  function automatic ins_t mk(logic [6:0] o, logic [2:0] f3,
                              logic [6:0] f7, logic z);
    ins_t i;
    i.op = o; i.f3 = f3; i.f7 = f7; i.z = z;
    return i;
  endfunction

  function automatic ins_t gen();
    logic [6:0] calc [7] = '{7'b0000000, 7'b0000100, 7'b0001000,
      7'b0001100, 7'b1010000, 7'b1100000, 7'b1101000};
    logic [6:0] ops [13] = '{LOAD, FLW, STORE, FSW, REG, IMM, AUIPC,
      BR, JAL, JALR, LUI, IOIN, IOOUT};
    ins_t i;
    int c = $urandom_range(0, 16);
    i.f3 = 3'($urandom);
    i.f7 = {1'b0, 1'($urandom), 5'd0};
    i.z  = 1'($urandom);
    if (c < 13) i.op = ops[c];
    else begin
      i.op = FP;
      case (c)
        13: i.f7 = 7'b1110000;
        14: i.f7 = 7'b1111000;
        15: begin i.f7 = 7'b0010000; i.f3 = 3'b001; end
        default: i.f7 = calc[$urandom_range(0, 6)];
      endcase
    end
    return i;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_fetch(input int target);
    for (int t = 0; t < 400; t++) begin
      if (fetch_cnt >= target) return;
      cyc();
    end
    checks++; errors++;
    $display("FAIL fetch_timeout got %0d expected %0d", fetch_cnt, target);
  endtask

  task automatic drain();
    int t = 0;
    while ((eq.size() != 0 || rq.size() != 0) && t < 400) begin
      cyc();
      t++;
    end
    checks++;
    if (eq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending expected 0",
               eq.size(), rq.size());
    end
  endtask

  // readies: always-on in fast mode, coin flips otherwise
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_ready = fast ? 1'b1 : 1'($urandom);
      fpu_valid = hold_fpu ? 1'b0 : (fast ? 1'b1 : 1'($urandom));
      rx_valid  = fast ? 1'b1 : 1'($urandom);
      tx_ready  = fast ? 1'b1 : 1'($urandom);
    end
  end

  // monitor: pops an expectation for every strobe cycle and retire
  initial begin
    int unsigned prev = 0;
    int since = 0;
    forever begin
      ev_t a;
      exp_t x;
      ret_t r;
      @(negedge clk);
      if (rst) begin
        prev = 0;
        since = 0;
        continue;
      end
      since++;
      if (instret != prev) begin
        prev = instret;
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL retire got %0d expected none", instret);
        end else begin
          r = rq.pop_front();
          if (instret != r.cnt || (r.cycles >= 0 && since != r.cycles)) begin
            errors++;
            $display("FAIL retire got %0d/%0d cyc expected %0d/%0d cyc",
                     instret, since, r.cnt, r.cycles);
          end
        end
        since = 0;
      end
      a = '0;
      a.pcen = pcen;
      a.pcsrc = pcen ? pcsrc : 2'd0;
      a.irwrite = irwrite;
      a.pcbufwrite = pcbufwrite;
      a.regwrite = regwrite;
      a.regsrc = regwrite ? regsrc : 3'd0;
      a.fregwrite = fregwrite;
      a.fregsrc = fregwrite ? fregsrc : 2'd0;
      a.fpu_go = fpu_go;
      if (fpu_go) begin
        a.fpucontrol = fpucontrol; a.mode = mode; a.fpusrca = fpusrca;
      end
      a.rx_ack = rx_ack;
      a.tx_fire = tx_valid & tx_ready;
      a.mem_fire = mem_req & mem_ready;
      if (a.mem_fire) begin
        a.mem_we = mem_we; a.iord = iord; a.iorf = iorf;
      end
      if (a != '0) begin
        if (irwrite) fetch_cnt++;
        checks++;
        if (eq.size() == 0) begin
          errors++;
          $display("FAIL event got %h expected none", a);
        end else begin
          x = eq.pop_front();
          if (x.chk_alu) begin
            a.alusrca = alusrca; a.alusrcb = alusrcb;
            a.alucontrol = alucontrol;
          end
          if (a !== x.ev) begin
            errors++;
            $display("FAIL event got %h expected %h", a, x.ev);
          end
        end
      end
    end
  end

  task automatic start_phase(input bit f);
    fast = f;
    hold_fpu = 0;
    run = 0;
    rst = 1;
    op = '0; funct3 = '0; funct7 = '0; zero = 0;
    cyc();
    cyc();
    eq.delete();
    rq.delete();
    chk("reset_out", longint'(outv), 0);
    chk("reset_instret", longint'(instret), 0);
    rst = 0;
    fetch_cnt = 0;
    model_cnt = 0;
  endtask

  task automatic run_prog(input ins_t prog[$]);
    int c;
    ret_t r;
    push_fetch();
    run = 1;
    for (int k = 0; k < prog.size(); k++) begin
      wait_fetch(fetch_cnt < k + 1 ? k + 1 : fetch_cnt);
      op = prog[k].op; funct3 = prog[k].f3;
      funct7 = prog[k].f7; zero = prog[k].z;
      if (k == prog.size() - 1) run = 0;
      model(prog[k], c);
      model_cnt++;
      r.cnt = model_cnt;
      r.cycles = (fast && k > 0) ? c : -1;
      rq.push_back(r);
      if (k != prog.size() - 1) push_fetch();
    end
    drain();
    repeat (3) cyc();
    chk("final_instret", longint'(instret), longint'(model_cnt));
    chk("idle_out", longint'(outv), 0);
  endtask

  initial begin
    ins_t p[$];
    ev_t e;
    rst = 1; run = 0;
    op = '0; funct3 = '0; funct7 = '0; zero = 0;

    start_phase(1);
    p = '{mk(IMM, 3'b000, 7'd0, 0), mk(BR, 3'b000, 7'd0, 1),
          mk(BR, 3'b001, 7'd0, 0), mk(LOAD, 3'b010, 7'd0, 0),
          mk(STORE, 3'b010, 7'd0, 0), mk(FSW, 3'b010, 7'd0, 0),
          mk(FLW, 3'b010, 7'd0, 0), mk(REG, 3'b000, 7'b0100000, 0),
          mk(JAL, 3'b000, 7'd0, 0), mk(JALR, 3'b000, 7'd0, 0),
          mk(LUI, 3'b000, 7'd0, 0), mk(AUIPC, 3'b000, 7'd0, 0),
          mk(FP, 3'b000, 7'b0000000, 0), mk(FP, 3'b001, 7'b1100000, 0),
          mk(FP, 3'b000, 7'b1110000, 0), mk(FP, 3'b000, 7'b1111000, 0),
          mk(FP, 3'b001, 7'b0010000, 0), mk(FP, 3'b000, 7'b1101000, 0),
          mk(IOIN, 3'b000, 7'd0, 0), mk(IOOUT, 3'b000, 7'd0, 0)};
    run_prog(p);

    start_phase(0);
    p.delete();
    for (int k = 0; k < 80; k++) p.push_back(gen());
    run_prog(p);

    start_phase(1);
    p.delete();
    for (int k = 0; k < 40; k++) p.push_back(gen());
    run_prog(p);

    // undefined opcode, then undefined sign-injection variant
    for (int v = 0; v < 2; v++) begin
      start_phase(1);
      push_fetch();
      run = 1;
      wait_fetch(1);
      if (v == 0) op = 7'b1111111;
      else begin op = FP; funct7 = 7'b0010000; funct3 = 3'b000; end
      repeat (6) cyc();
      run = 0;
      repeat (3) cyc();
      chk("illegal_out", longint'(outv), 1);
      chk("illegal_instret", longint'(instret), 0);
    end

    // reset while waiting on the FPU
    start_phase(1);
    p = '{mk(IMM, 3'b000, 7'd0, 0), mk(IMM, 3'b000, 7'd0, 0),
          mk(IMM, 3'b000, 7'd0, 0)};
    run_prog(p);
    hold_fpu = 1;
    fetch_cnt = 0;
    push_fetch();
    run = 1;
    wait_fetch(1);
    op = FP; funct3 = 3'b000; funct7 = 7'b0000000;
    e = '0;
    e.fpu_go = 1;
    push_ev(e, 0);
    drain();
    repeat (4) cyc();
    chk("fpu_wait_go", longint'(fpu_go), 0);
    chk("fpu_wait_instret", longint'(instret), 3);
    rst = 1;
    cyc();
    chk("rst_mid_instret", longint'(instret), 0);
    chk("rst_mid_out", longint'(outv), 0);
    run = 0;
    rst = 0;
    hold_fpu = 0;
    repeat (3) cyc();
    chk("post_rst_out", longint'(outv), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
